// File: rtl/mem_access_pkg.sv
// Shared types and lane helpers for the mem_access_unit load/store front-end.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WRITE,
    RESP
  } mau_state_e;

  localparam int unsigned LANE_W    = 8;
  localparam int unsigned HALF_W    = 16;
  localparam int unsigned NUM_LANES = 4;

  // Encoding 3 is reserved and behaves as a full word.
  function automatic mem_size_e decode_size(input logic [1:0] raw);
    case (raw)
      2'd0:    return SZ_BYTE;
      2'd1:    return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] lo);
    case (size)
      SZ_HALF: return lo[0];
      SZ_WORD: return |lo;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] align_lo(input mem_size_e size, input logic [1:0] lo);
    case (size)
      SZ_HALF: return {lo[1], 1'b0};
      SZ_WORD: return 2'b00;
      default: return lo;
    endcase
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old, input logic [31:0] wdata,
                                              input mem_size_e size, input logic [1:0] lo);
    logic [31:0] result;
    result = old;
    case (size)
      SZ_BYTE: begin
        case (lo)
          2'd0: result[7:0]   = wdata[7:0];
          2'd1: result[15:8]  = wdata[7:0];
          2'd2: result[23:16] = wdata[7:0];
          default: result[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lo[1]) result[31:16] = wdata[15:0];
        else       result[15:0]  = wdata[15:0];
      end
      default: result = wdata;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Core-side request/response handshake of mem_access_unit.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Selects the addressed byte/half/word lane from a RAM word and sign- or zero-extends it.
module load_extend
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  mem_size_e   size,
  input  logic        uext,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (addr)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = addr[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    data = '0;
    case (size)
      SZ_BYTE: data = uext ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: data = uext ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding RV32 load/store front-end for a word RAM without byte enables.
// Define MEM_MISALIGN_TRAP_EN to report misaligned accesses via rsp_err instead of aligning them.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_access_unit_if.slave      bus,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic [DATA_WIDTH-1:0] ram_wd,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_rd
);

  mau_state_e            state, state_next;
  logic                  l_we;
  mem_size_e             l_size;
  logic                  l_uns;
  logic [ADDR_WIDTH+1:0] l_addr;
  logic [DATA_WIDTH-1:0] l_wdata;
  logic [DATA_WIDTH-1:0] merge_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] ext_data;
  mem_size_e             sz_in;
  logic                  accept;
  logic                  trap_in;

  assign sz_in  = decode_size(bus.req_size);
  assign accept = (state == IDLE) && bus.req_valid;

  // Aliased high address bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, bus.req_addr[31:ADDR_WIDTH+2]};

`ifdef MEM_MISALIGN_TRAP_EN
  logic err_q;
  assign trap_in     = is_misaligned(sz_in, bus.req_addr[1:0]);
  assign bus.rsp_err = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         err_q <= 1'b0;
    else if (accept) err_q <= trap_in;
  end
`else
  assign trap_in     = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  load_extend u_load_extend (
    .word (ram_rd),
    .addr (l_addr[1:0]),
    .size (l_size),
    .uext (l_uns),
    .data (ext_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ram_we     = 1'b0;
    ram_wd     = '0;
    case (state)
      IDLE: begin
        if (accept) state_next = trap_in ? RESP : ACCESS;
      end
      ACCESS: begin
        if (l_we && l_size == SZ_WORD) begin
          ram_we = 1'b1;
          ram_wd = l_wdata;
        end
        state_next = (l_we && l_size != SZ_WORD) ? WRITE : RESP;
      end
      WRITE: begin
        ram_we     = 1'b1;
        ram_wd     = merge_lanes(merge_q, l_wdata, l_size, l_addr[1:0]);
        state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Misaligned low bits are forced to the natural alignment at latch time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_we    <= 1'b0;
      l_size  <= SZ_BYTE;
      l_uns   <= 1'b0;
      l_addr  <= '0;
      l_wdata <= '0;
      merge_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        l_we    <= bus.req_we;
        l_size  <= sz_in;
        l_uns   <= bus.req_unsigned;
        l_addr  <= {bus.req_addr[ADDR_WIDTH+1:2], align_lo(sz_in, bus.req_addr[1:0])};
        l_wdata <= bus.req_wdata;
        rdata_q <= '0;
      end
      if (state == ACCESS) begin
        merge_q <= ram_rd;
        if (!l_we) rdata_q <= ext_data;
      end
    end
  end

  assign ram_a         = l_addr[ADDR_WIDTH+1:2];
  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;

endmodule
